// File: rtl/niosii_processor_st_writer_pkg.sv
// Shared types, constants and lane helpers for the stream-to-RAM writer.
// NIOSII_ST_WRITER_BIG_ENDIAN_EN selects big-endian lane packing.
package niosii_processor_st_writer_pkg;

    localparam int MEM_WORDS_DEF = 33000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_PACK  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    function automatic logic [1:0] lane_idx(input logic [1:0] fill);
`ifdef NIOSII_ST_WRITER_BIG_ENDIAN_EN
        return 2'd3 - fill;
`else
        return fill;
`endif
    endfunction

    function automatic logic [3:0] be_mask(input logic [2:0] n);
        logic [3:0] m;
        unique case (n)
`ifdef NIOSII_ST_WRITER_BIG_ENDIAN_EN
            3'd1:    m = 4'b1000;
            3'd2:    m = 4'b1100;
            3'd3:    m = 4'b1110;
`else
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
`endif
            3'd4:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/niosii_processor_st_byte_packer.sv
// Byte lane accumulator: presents the word including the incoming byte
// so the caller can register it straight into the RAM write port.
module niosii_processor_st_byte_packer
    import niosii_processor_st_writer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic [3:0]  be,
    output logic        full
);

    logic [31:0] acc;
    logic [1:0]  fill;
    logic [1:0]  lane;

    assign lane = lane_idx(fill);
    assign full = (fill == 2'd3);
    assign be   = be_mask({1'b0, fill} + 3'd1);

    always_comb begin
        word = acc;
        word[{lane, 3'b000} +: 8] = data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc  <= '0;
            fill <= '0;
        end else if (clear) begin
            acc  <= '0;
            fill <= '0;
        end else if (push) begin
            acc  <= word;
            fill <= fill + 2'd1;
        end
    end

endmodule

// File: rtl/niosii_processor_st_to_onchip_writer.sv
// Captures an 8-bit Avalon-ST packet into on-chip RAM, four bytes per word.
// NIOSII_ST_WRITER_BIG_ENDIAN_EN selects big-endian lane packing.
module niosii_processor_st_to_onchip_writer
    import niosii_processor_st_writer_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic [15:0] max_words,
    input  logic [7:0]  st_data,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic        st_sop,
    input  logic        st_eop,
    output logic [15:0] mem_address,
    output logic [3:0]  mem_byteenable,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] words_written
);

    logic [1:0]  state;
    logic        ending;
    logic [15:0] addr_ptr;
    logic [15:0] max_q;
    logic [16:0] span;
    logic        reject;
    logic        start_ok;
    logic        accept;
    logic        pack_push;
    logic        issue;
    logic        win_full;
    logic [31:0] pack_word;
    logic [3:0]  pack_be;
    logic        pack_full;

    assign span     = {1'b0, base_addr} + {1'b0, max_words};
    assign reject   = (max_words == 16'd0) || (span > 17'(MEM_WORDS));
    assign start_ok = start && (state == S_IDLE) && !reject;
    assign busy     = (state != S_IDLE);
    // ending covers the write cycle of the final word; no more bytes then
    assign st_ready = busy && !ending;
    assign accept   = st_valid && st_ready;
    assign win_full = ((words_written + 16'd1) == max_q);

    always_comb begin
        pack_push = 1'b0;
        unique case (state)
            S_ARMED: pack_push = accept && st_sop;
            S_PACK:  pack_push = accept;
            default: pack_push = 1'b0;
        endcase
    end

    assign issue = pack_push && (pack_full || st_eop);

    niosii_processor_st_byte_packer u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (issue || start_ok),
        .push    (pack_push),
        .data    (st_data),
        .word    (pack_word),
        .be      (pack_be),
        .full    (pack_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            ending         <= 1'b0;
            addr_ptr       <= '0;
            max_q          <= '0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            done           <= 1'b0;
            overflow       <= 1'b0;
            words_written  <= '0;
        end else begin
            done           <= 1'b0;
            mem_write      <= 1'b0;
            mem_chipselect <= 1'b0;
            if (issue) begin
                mem_write      <= 1'b1;
                mem_chipselect <= 1'b1;
                mem_address    <= addr_ptr;
                mem_writedata  <= pack_word;
                mem_byteenable <= pack_be;
                addr_ptr       <= addr_ptr + 16'd1;
                words_written  <= words_written + 16'd1;
            end
            unique case (state)
                S_IDLE: begin
                    if (start && reject) begin
                        done          <= 1'b1;
                        overflow      <= 1'b1;
                        words_written <= '0;
                    end else if (start_ok) begin
                        state         <= S_ARMED;
                        addr_ptr      <= base_addr;
                        max_q         <= max_words;
                        words_written <= '0;
                        overflow      <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (accept && st_sop) begin
                        state  <= S_PACK;
                        ending <= st_eop;
                    end
                end
                S_PACK: begin
                    if (ending) begin
                        state  <= S_IDLE;
                        ending <= 1'b0;
                        done   <= 1'b1;
                    end else if (issue && st_eop) begin
                        ending <= 1'b1;
                    end else if (issue && win_full) begin
                        overflow <= 1'b1;
                        state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (accept && st_eop) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_niosii_processor_st_to_onchip_writer.sv
// Scoreboard bench for the stream-to-RAM writer.
module tb_niosii_processor_st_to_onchip_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] max_words = '0;
    logic [7:0]  st_data = '0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic        st_sop = 1'b0;
    logic        st_eop = 1'b0;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] words_written;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;
    wr_t exp_q[$];

    niosii_processor_st_to_onchip_writer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .max_words      (max_words),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_sop         (st_sop),
        .st_eop         (st_eop),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .words_written  (words_written)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && mem_chipselect !== mem_write) begin
            checks++;
            errors++;
            $display("FAIL cs_vs_write: cs=%b write=%b", mem_chipselect, mem_write);
        end
        if (mem_write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h be=%b",
                         mem_address, mem_writedata, mem_byteenable);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_address !== e.a || mem_writedata !== e.d ||
                    mem_byteenable !== e.be) begin
                    errors++;
                    $display("FAIL write: got %h/%h/%b want %h/%h/%b",
                             mem_address, mem_writedata, mem_byteenable,
                             e.a, e.d, e.be);
                end
            end
        end
    end

    task automatic expect_pkt(input logic [15:0] base, input int maxw,
                              input logic [7:0] b0, input int n);
        int nw;
        nw = (n + 3) / 4;
        if (nw > maxw) nw = maxw;
        for (int w = 0; w < nw; w++) begin
            wr_t e;
            e.a  = base + 16'(w);
            e.d  = '0;
            e.be = '0;
            for (int l = 0; l < 4; l++) begin
                int idx;
                int lane;
                idx = w * 4 + l;
`ifdef NIOSII_ST_WRITER_BIG_ENDIAN_EN
                lane = 3 - l;
`else
                lane = l;
`endif
                if (idx < n) begin
                    e.d[lane*8 +: 8] = b0 + 8'(idx);
                    e.be[lane] = 1'b1;
                end
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] m);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        max_words = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b0, input int n, input bit sop,
                        input bit eop, input int start_at);
        for (int i = 0; i < n; i++) begin
            st_data  = b0 + 8'(i);
            st_sop   = sop && (i == 0);
            st_eop   = eop && (i == n - 1);
            st_valid = 1'b1;
            start    = (i == start_at);
            if (i == start_at) base_addr = 16'h0500;
            checks++;
            if (st_ready !== 1'b1) begin
                errors++;
                $display("FAIL st_ready_beat%0d: got %b want 1", i, st_ready);
            end
            @(posedge clk); #1;
        end
        st_valid = 1'b0;
        st_sop   = 1'b0;
        st_eop   = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc, input string name);
        int c;
        c = 0;
        while (done !== 1'b1 && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout: done=%b after %0d cycles", name, done, c);
        end else if (c != exp_cyc) begin
            errors++;
            $display("FAIL %s_done_latency: got %0d want %0d", name, c, exp_cyc);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_at_done: got %b want 0", name, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: got %b want 0", name, done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes: got %0d left want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_flags(input string name, input logic [15:0] ww,
                               input logic ov);
        checks++;
        if (words_written !== ww || overflow !== ov) begin
            errors++;
            $display("FAIL %s_flags: ww=%0d ov=%b want ww=%0d ov=%b",
                     name, words_written, overflow, ww, ov);
        end
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (st_ready !== 1'b0 || mem_write !== 1'b0 || mem_chipselect !== 1'b0 ||
            mem_address !== 16'h0 || mem_byteenable !== 4'h0 ||
            mem_writedata !== 32'h0 || busy !== 1'b0 || done !== 1'b0 ||
            overflow !== 1'b0 || words_written !== 16'h0) begin
            errors++;
            $display("FAIL %s: rdy=%b wr=%b cs=%b a=%h be=%b d=%h busy=%b done=%b ov=%b ww=%0d want all 0",
                     name, st_ready, mem_write, mem_chipselect, mem_address,
                     mem_byteenable, mem_writedata, busy, done, overflow,
                     words_written);
        end
    endtask

    task automatic test_reset();
        #2;
        check_reset_vals("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("post_reset");
    endtask

    task automatic test_full_words();
        do_start(16'h0100, 16'd4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL full_busy: got %b want 1", busy);
        end
        expect_pkt(16'h0100, 4, 8'h01, 8);
        send(8'h01, 8, 1'b1, 1'b1, -1);
        wait_done(1, "full");
        check_flags("full", 16'd2, 1'b0);
    endtask

    task automatic test_partial();
        do_start(16'h0200, 16'd4);
        expect_pkt(16'h0200, 4, 8'h01, 6);
        send(8'h01, 6, 1'b1, 1'b1, -1);
        wait_done(1, "partial");
        check_flags("partial", 16'd2, 1'b0);
    endtask

    task automatic test_overflow();
        do_start(16'h0300, 16'd2);
        expect_pkt(16'h0300, 2, 8'h10, 12);
        send(8'h10, 12, 1'b1, 1'b1, -1);
        wait_done(0, "ovf");
        check_flags("ovf", 16'd2, 1'b1);
    endtask

    task automatic test_discard_and_busy_start();
        do_start(16'h0400, 16'd4);
        check_flags("discard_clear", 16'd0, 1'b0);
        send(8'hE0, 3, 1'b0, 1'b0, 1);
        expect_pkt(16'h0400, 4, 8'hA0, 4);
        send(8'hA0, 4, 1'b1, 1'b1, 2);
        wait_done(1, "discard");
        check_flags("discard", 16'd1, 1'b0);
    endtask

    task automatic test_reject();
        do_start(16'd32999, 16'd2);
        checks++;
        if (st_ready !== 1'b0) begin
            errors++;
            $display("FAIL reject_ready: got %b want 0", st_ready);
        end
        wait_done(0, "reject_range");
        check_flags("reject_range", 16'd0, 1'b1);
        do_start(16'h0000, 16'd0);
        wait_done(0, "reject_zero");
        check_flags("reject_zero", 16'd0, 1'b1);
        do_start(16'd32998, 16'd2);
        expect_pkt(16'd32998, 2, 8'h40, 8);
        send(8'h40, 8, 1'b1, 1'b1, -1);
        wait_done(1, "edge_ok");
        check_flags("edge_ok", 16'd2, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_start(16'h0800, 16'd4);
        expect_pkt(16'h0800, 4, 8'h5A, 1);
        send(8'h5A, 1, 1'b1, 1'b1, -1);
        wait_done(1, "one_byte");
        check_flags("one_byte", 16'd1, 1'b0);
        do_start(16'h0900, 16'd4);
        expect_pkt(16'h0900, 4, 8'h61, 5);
        send(8'h61, 5, 1'b1, 1'b1, -1);
        wait_done(1, "five_byte");
        check_flags("five_byte", 16'd2, 1'b0);
    endtask

    task automatic test_mid_reset();
        do_start(16'h0600, 16'd4);
        send(8'h11, 2, 1'b1, 1'b0, -1);
        reset_n = 1'b0;
        #2;
        check_reset_vals("mid_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("mid_reset_release");
        do_start(16'h0700, 16'd4);
        expect_pkt(16'h0700, 4, 8'h21, 4);
        send(8'h21, 4, 1'b1, 1'b1, -1);
        wait_done(1, "after_reset");
        check_flags("after_reset", 16'd1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_partial();
        test_overflow();
        test_discard_and_busy_start();
        test_reject();
        test_back_to_back();
        test_mid_reset();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/niosii_processor_st_to_onchip_writer.md
# niosII_processor_st_to_onchip_writer

Streaming-capture stage that sits directly upstream of the 32-bit single-port on-chip RAM of the Nios II system. It accepts an 8-bit Avalon-ST byte stream, packs four bytes per word, and writes consecutive words into the RAM through its second slave port, starting at a programmed word address. Packets longer than the programmed window are truncated and flagged. A done pulse signals completion so the CPU can read the captured frame from port s1.

## Interface
- MEM_WORDS, 33000: RAM depth in 32-bit words; legal word addresses are 0..MEM_WORDS-1.
- clk  in  1  system clock; every register samples on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that arms a capture; ignored while busy=1.
- base_addr  in  16  first word address; sampled on start.
- max_words  in  16  word capacity of the capture window; sampled on start.
- st_data  in  8  stream byte.
- st_valid  in  1  byte valid.
- st_ready  out  1  byte accepted when st_valid & st_ready.
- st_sop  in  1  first byte of packet.
- st_eop  in  1  last byte of packet.
- mem_address  out  16  RAM word address.
- mem_byteenable  out  4  RAM byte lanes.
- mem_chipselect  out  1  RAM select; asserted only together with mem_write.
- mem_write  out  1  RAM write strobe, one cycle per word.
- mem_writedata  out  32  packed word.
- busy  out  1  high from the cycle after an accepted start until the cycle of done.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky truncation flag; cleared by the next accepted start.
- words_written  out  16  words written in the current or last capture.

## Operation
- States: IDLE, ARMED, PACK, DRAIN.
- IDLE: st_ready=0. An accepted start latches base_addr and max_words, clears words_written and overflow, and moves to ARMED.
- Start rejection: if max_words==0 or base_addr+max_words > MEM_WORDS (17-bit compare), the block pulses done the next cycle, stays in IDLE, sets overflow, and makes no write.
- ARMED: st_ready=1. Bytes without sop are consumed and discarded. An sop beat is stored in lane 0 and the state moves to PACK; sop&eop on the same beat is a one-byte packet.
- PACK: st_ready=1 and one byte is accepted per cycle into lanes 0,1,2,3 in order.
  - When the 4th lane fills, or on an eop beat, the block issues one write: byteenable covers the filled lanes (eop after 1/2/3 bytes gives 0001/0011/0111), and unfilled lanes carry 0.
  - After each write, mem_address increments and words_written increments.
  - An sop beat seen in PACK is treated as ordinary data.
- Window full: if a write makes words_written==max_words and the packet has not ended, overflow is set and the state moves to DRAIN.
- DRAIN: st_ready=1 and bytes are discarded up to and including eop.
- Completion: an eop write in PACK, or eop in DRAIN, causes done the following cycle and a return to IDLE.
- The RAM has no wait-state, so st_ready never deasserts inside PACK or DRAIN.
- Reset mid-capture: the partial word is lost and all state returns to reset values. Words already written stay in RAM.
- Reset values: st_ready=0, mem_write=0, mem_chipselect=0, mem_address=0, mem_byteenable=0, mem_writedata=0, busy=0, done=0, overflow=0, words_written=0.

## Timing
- Outputs toward the RAM are registered.
- mem_write is asserted in the cycle after the handshake that completes a word or carries eop.
- Throughput is one byte per cycle, so at most one write every 4 cycles (an eop can follow the previous write at the minimum spacing of 1 cycle).
- done is asserted 1 cycle after the final write, or 1 cycle after eop in DRAIN.
- busy falls in the same cycle that done rises.
- st_ready rises 1 cycle after an accepted start.

## Configuration
- NIOSII_ST_WRITER_BIG_ENDIAN_EN:
  - Defined: byte 0 of each word goes to lane 3, and partial-word byteenables are 1000/1100/1110.
  - Undefined: little-endian packing as described under Operation.

## Structure
- Shared package niosII_processor_st_writer_pkg contains the state enum, the MEM_WORDS default, and the lane-index and byteenable functions.
- Sub-module niosII_processor_st_byte_packer contains the lane accumulator, fill count, and byteenable generation. The top level holds the FSM, the address/count counters, and the flags.

## Test plan
- base=0x0100, max=4, packet of 8 bytes 0x01..0x08 -> writes 0x04030201@0x0100 and 0x08070605@0x0101, both be=1111; done the next cycle; words_written=2; overflow=0.
- Packet of 6 bytes -> second write has be=0011 and data 0x00000605.
- max=2, packet of 12 bytes -> 2 writes, overflow=1, remaining 4 bytes drained, done the cycle after eop.
- Bytes before sop in ARMED, and a start pulse while busy -> bytes are discarded, the start is ignored, and base_addr is unchanged.
- base=32999, max=2 -> immediate done with overflow=1 and no mem_write.
- reset_n low after 2 bytes of a word -> all outputs at reset values, no write issued; a new start captures correctly.
